// File: rtl/riscv_defines.sv
// Shared word/register widths, the EX->WB entry type and the skid-buffer state encoding.
package riscv_defines;

  localparam int unsigned RISCV_WORD_WIDTH     = 32;
  localparam int unsigned RISCV_REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [RISCV_WORD_WIDTH-1:0]     data;
    logic [RISCV_REG_ADDR_WIDTH-1:0] rd_addr;
    logic                            we;
  } ex_wb_entry_t;

  typedef enum logic [1:0] {
    SKB_EMPTY = 2'd0,
    SKB_FULL  = 2'd1,
    SKB_SKID  = 2'd2
  } skid_state_e;

  // Builds a writeback entry; x0 is hard-wired to zero, so its write enable is dropped here.
  function automatic ex_wb_entry_t make_entry(
    input logic [RISCV_WORD_WIDTH-1:0]     data,
    input logic [RISCV_REG_ADDR_WIDTH-1:0] rd_addr,
    input logic                            we
  );
    ex_wb_entry_t e;
    e.data    = data;
    e.rd_addr = rd_addr;
    e.we      = we && (rd_addr != {RISCV_REG_ADDR_WIDTH{1'b0}});
    return e;
  endfunction

endpackage

// File: rtl/ex_wb_skid.sv
// Generic 2-entry skid buffer over ex_wb_entry_t; the input ready is a pure register output.
module ex_wb_skid
  import riscv_defines::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  ex_wb_entry_t in_entry_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ex_wb_entry_t out_entry_o
);

  skid_state_e  state_q, state_d;
  ex_wb_entry_t main_q, main_d;
  ex_wb_entry_t skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         push_s, pop_s;

  assign push_s = in_valid_i && ready_q;
  assign pop_s  = (state_q != SKB_EMPTY) && out_ready_i;

  // Next-state, storage update and registered-ready computation.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKB_EMPTY: begin
        if (push_s) begin
          main_d  = in_entry_i;
          state_d = SKB_FULL;
        end else begin
          state_d = SKB_EMPTY;
        end
      end
      SKB_FULL: begin
        if (push_s && pop_s) begin
          main_d = in_entry_i;
        end else if (push_s) begin
          skid_d  = in_entry_i;
          state_d = SKB_SKID;
        end else if (pop_s) begin
          state_d = SKB_EMPTY;
        end else begin
          state_d = SKB_FULL;
        end
      end
      SKB_SKID: begin
        // Ready is low here, so only a pop can move the buffer.
        if (pop_s) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = SKB_FULL;
        end else begin
          state_d = SKB_SKID;
        end
      end
      default: begin
        state_d = SKB_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    ready_d = (state_d != SKB_SKID);
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SKB_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != SKB_EMPTY);
  assign out_entry_o = main_q;

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB stage: skid-buffered writeback, branch resolution from ALU bit 0, optional forwarding.
// Define EX_WB_FORWARD_EN to drive fwd_*; otherwise those ports are tied to zero.
module ex_wb_stage
  import riscv_defines::*;
(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ex_valid_i,
  output logic                            ex_ready_o,
  input  logic [RISCV_WORD_WIDTH-1:0]     alu_result_i,
  input  logic [RISCV_REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                            rd_we_i,
  input  logic                            is_branch_i,
  input  logic [RISCV_WORD_WIDTH-1:0]     branch_target_i,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic                            wb_we_o,
  output logic [RISCV_REG_ADDR_WIDTH-1:0] wb_rd_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0]     wb_data_o,
  output logic                            branch_taken_o,
  output logic [RISCV_WORD_WIDTH-1:0]     branch_target_o,
  output logic                            fwd_valid_o,
  output logic [RISCV_REG_ADDR_WIDTH-1:0] fwd_rd_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0]     fwd_data_o
);

  ex_wb_entry_t                in_entry_s;
  ex_wb_entry_t                head_s;
  logic                        head_valid_s;
  logic                        ready_s;
  logic                        accept_s;
  logic                        taken_q, taken_d;
  logic [RISCV_WORD_WIDTH-1:0] target_q, target_d;

  assign in_entry_s = make_entry(alu_result_i, rd_addr_i, rd_we_i);
  assign accept_s   = ex_valid_i && ready_s;

  ex_wb_skid u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (ex_valid_i),
    .in_ready_o  (ready_s),
    .in_entry_i  (in_entry_s),
    .out_valid_o (head_valid_s),
    .out_ready_i (wb_ready_i),
    .out_entry_o (head_s)
  );

  assign ex_ready_o   = ready_s;
  assign wb_valid_o   = head_valid_s;
  assign wb_we_o      = head_s.we;
  assign wb_rd_addr_o = head_s.rd_addr;
  assign wb_data_o    = head_s.data;

  // Branch decision: every compare op leaves its outcome in bit 0; independent of writeback stalls.
  always_comb begin
    taken_d  = 1'b0;
    target_d = target_q;
    if (accept_s && is_branch_i) begin
      taken_d  = alu_result_i[0];
      target_d = branch_target_i;
    end else begin
      taken_d  = 1'b0;
    end
  end

  // Branch pulse and target registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign branch_taken_o  = taken_q;
  assign branch_target_o = target_q;

`ifdef EX_WB_FORWARD_EN
  // Only the head entry is forwarded; the hazard unit stalls on the skid entry.
  assign fwd_valid_o   = head_valid_s && head_s.we;
  assign fwd_rd_addr_o = head_s.rd_addr;
  assign fwd_data_o    = head_s.data;
`else
  assign fwd_valid_o   = 1'b0;
  assign fwd_rd_addr_o = '0;
  assign fwd_data_o    = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: vector table plus scoreboarded multi-cycle sequences.
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_we, is_branch;
  logic [31:0] alu_result, br_target_in;
  logic [4:0]  ex_rd;
  logic        wb_valid, wb_ready, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  ex_wb_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_valid_i      (ex_valid),
    .ex_ready_o      (ex_ready),
    .alu_result_i    (alu_result),
    .rd_addr_i       (ex_rd),
    .rd_we_i         (ex_we),
    .is_branch_i     (is_branch),
    .branch_target_i (br_target_in),
    .wb_valid_o      (wb_valid),
    .wb_ready_i      (wb_ready),
    .wb_we_o         (wb_we),
    .wb_rd_addr_o    (wb_rd),
    .wb_data_o       (wb_data),
    .branch_taken_o  (br_taken),
    .branch_target_o (br_target),
    .fwd_valid_o     (fwd_valid),
    .fwd_rd_addr_o   (fwd_rd),
    .fwd_data_o      (fwd_data)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic [31:0] tgt;
    logic        exp_wb_valid;
    logic        exp_wb_we;
    logic        exp_taken;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd,
                       input logic we, input logic br, input logic [31:0] tgt);
    ex_valid     = v;
    alu_result   = d;
    ex_rd        = rd;
    ex_we        = we;
    is_branch    = br;
    br_target_in = tgt;
  endtask

  // Scoreboard step at the falling edge, then advance past the next rising edge.
  task automatic tick();
    exp_t e;
    exp_t h;
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
    end else begin
      if (wb_valid && wb_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: got rd %0d data 0x%08h expected no entry", wb_rd, wb_data);
        end else begin
          h = sb_q.pop_front();
          check("sb_data", wb_data, h.data);
          check("sb_rd", {27'd0, wb_rd}, {27'd0, h.rd});
          check("sb_we", {31'd0, wb_we}, {31'd0, h.we});
        end
      end
      if (ex_valid && ex_ready) begin
        e.data = alu_result;
        e.rd   = ex_rd;
        e.we   = ex_we && (ex_rd != 5'd0);
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_fwd(input logic v, input logic we);
`ifdef EX_WB_FORWARD_EN
    return v && we;
`else
    return 1'b0 & v & we;
`endif
  endfunction

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0005, 5'd3,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 5'd0,  1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FFFE, 5'd0,  1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h1234_5678, 5'd31, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'hA5A5_A5A5, 5'd31, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'h0000_0001, 5'd7,  1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};

    rst      = 1'b1;
    wb_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_br_taken", {31'd0, br_taken}, 32'd0);
    check("rst_br_target", br_target, 32'd0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    rst = 1'b0;

    // Streaming vectors with writeback always ready.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].rd, vecs[i].we, vecs[i].br, vecs[i].tgt);
      tick();
      check($sformatf("vec%0d_ex_ready", i), {31'd0, ex_ready}, 32'd1);
      check($sformatf("vec%0d_wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].exp_wb_valid});
      if (vecs[i].exp_wb_valid) begin
        check($sformatf("vec%0d_wb_we", i), {31'd0, wb_we}, {31'd0, vecs[i].exp_wb_we});
        check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].data);
      end
      check($sformatf("vec%0d_fwd_valid", i), {31'd0, fwd_valid},
            {31'd0, exp_fwd(vecs[i].exp_wb_valid, vecs[i].exp_wb_we)});
      check($sformatf("vec%0d_br_taken", i), {31'd0, br_taken}, {31'd0, vecs[i].exp_taken});
      if (vecs[i].exp_taken) check($sformatf("vec%0d_br_target", i), br_target, vecs[i].tgt);
    end

    // Backpressure: A and B fill the buffer, C is held until writeback drains.
    wb_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 5'd1, 1'b1, 1'b0, 32'h0);
    tick();
    check("bp_a_ready", {31'd0, ex_ready}, 32'd1);
    check("bp_a_head", wb_data, 32'hAAAA_0001);
    drive(1'b1, 32'hBBBB_0002, 5'd2, 1'b1, 1'b0, 32'h0);
    tick();
    check("bp_b_ready", {31'd0, ex_ready}, 32'd0);
    check("bp_b_head", wb_data, 32'hAAAA_0001);
    drive(1'b1, 32'hCCCC_0003, 5'd3, 1'b1, 1'b0, 32'h0);
    tick();
    check("bp_c_ready", {31'd0, ex_ready}, 32'd0);
    check("bp_hold_data", wb_data, 32'hAAAA_0001);
    check("bp_hold_rd", {27'd0, wb_rd}, 32'd1);
    check("bp_hold_valid", {31'd0, wb_valid}, 32'd1);
    wb_ready = 1'b1;
    tick();
    check("bp_head_b", wb_data, 32'hBBBB_0002);
    check("bp_ready_back", {31'd0, ex_ready}, 32'd1);
    tick();
    check("bp_head_c", wb_data, 32'hCCCC_0003);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    check("bp_drained", {31'd0, wb_valid}, 32'd0);
    check("bp_sb_empty", sb_q.size(), 32'd0);

    // Taken branch accepted while writeback is stalled still pulses in the next cycle.
    wb_ready = 1'b0;
    drive(1'b1, 32'h0000_0042, 5'd4, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0000_0001, 5'd0, 1'b0, 1'b1, 32'h0000_0440);
    tick();
    check("bpbr_taken", {31'd0, br_taken}, 32'd1);
    check("bpbr_target", br_target, 32'h0000_0440);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    check("bpbr_pulse_end", {31'd0, br_taken}, 32'd0);
    check("bpbr_skid_ready", {31'd0, ex_ready}, 32'd0);

    // Reset while in SKID drops both entries.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("skid_rst_valid", {31'd0, wb_valid}, 32'd0);
    check("skid_rst_ready", {31'd0, ex_ready}, 32'd1);
    wb_ready = 1'b1;
    tick();
    check("skid_rst_stale1", {31'd0, wb_valid}, 32'd0);
    tick();
    check("skid_rst_stale2", {31'd0, wb_valid}, 32'd0);
    check("final_sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Pipeline stage directly downstream of the ALU. Registers each ALU result with its destination register and hands it to register-file writeback over a valid/ready handshake. A 2-entry skid buffer lets `ex_ready_o` be a pure register output. The stage also resolves conditional branches from the ALU comparison result and exports a forwarding view of the oldest buffered result to the operand-select logic.

## Interface
Parameters:
- `RISCV_WORD_WIDTH`, 32 (package constant, not overridden): data and address width.

Ports:
- `clk_i`  in  1  single clock; everything is rising-edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `ex_valid_i`  in  1  ALU result valid this cycle.
- `ex_ready_o`  out  1  stage can accept (registered).
- `alu_result_i`  in  RISCV_WORD_WIDTH  ALU output.
- `rd_addr_i`  in  5  destination register.
- `rd_we_i`  in  1  instruction writes rd.
- `is_branch_i`  in  1  instruction is a conditional branch (ALU ran a compare op).
- `branch_target_i`  in  RISCV_WORD_WIDTH  precomputed branch target.
- `wb_valid_o`  out  1  writeback entry valid.
- `wb_ready_i`  in  1  writeback consumes the entry.
- `wb_we_o`  out  1  write enable of the head entry.
- `wb_rd_addr_o`  out  5  head rd.
- `wb_data_o`  out  RISCV_WORD_WIDTH  head data.
- `branch_taken_o`  out  1  one-cycle pulse: taken branch resolved.
- `branch_target_o`  out  RISCV_WORD_WIDTH  target qualified by `branch_taken_o`.
- `fwd_valid_o`  out  1  forwarding entry valid (only with `EX_WB_FORWARD_EN`).
- `fwd_rd_addr_o`  out  5  forwarding rd.
- `fwd_data_o`  out  RISCV_WORD_WIDTH  forwarding data.

## Operation
- Accept: `ex_valid_i && ex_ready_o`. Every accepted entry is enqueued, branches included.
- Enqueued entry: {`alu_result_i`, `rd_addr_i`, `rd_we_i && (rd_addr_i != 0)`}. Writes to x0 are suppressed here.
- Pop: `wb_valid_o && wb_ready_i`.
- FSM states (owned by sub-module):
  - EMPTY: main register invalid.
  - FULL: main valid, skid empty.
  - SKID: main and skid both valid.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + accept, no pop -> SKID (entry goes to skid).
  - FULL + accept + pop -> FULL (main reloaded from input).
  - FULL + pop, no accept -> EMPTY.
  - SKID + pop -> FULL (skid moves to main). No accept is possible in SKID.
- `ex_ready_o` is 1 in EMPTY/FULL and 0 in SKID. It is computed for the next state and registered.
- Order is strictly FIFO. `wb_*` outputs always show the main entry. Data fields are don't-care when `wb_valid_o`=0.
- Branch resolution:
  - On accept with `is_branch_i`=1, `branch_taken_o` is set to `alu_result_i[0]` for the next cycle only, and `branch_target_o` is registered with it.
  - Bit 0 is the decision for every compare op (EQ/NE/GTS/GTU/GES/GEU/LTS/LTU/LES/LEU).
  - Resolution never waits on `wb_ready_i`.
- Forwarding: `fwd_*` mirrors the main entry. `fwd_valid_o` = `wb_valid_o && wb_we_o`. The skid entry is never forwarded; the hazard unit stalls on it.

## Timing
- Latency: accept in cycle N -> `wb_valid_o` in N+1 (EMPTY case).
- Throughput: 1/cycle while `wb_ready_i`=1.
- `branch_taken_o`: asserted in N+1, exactly one cycle per taken branch.
- Reset values: state EMPTY, `ex_ready_o`=1, `wb_valid_o`=0, `wb_we_o`=0, `wb_rd_addr_o`=0, `wb_data_o`=0, `branch_taken_o`=0, `branch_target_o`=0, `fwd_valid_o`=0. Skid contents are cleared.
- Reset mid-operation: all buffered entries are dropped. Reset has priority over a simultaneous accept or pop.
- `wb_ready_i` may toggle freely. The head entry and `wb_*` must stay stable while `wb_valid_o && !wb_ready_i`.
- `ex_valid_i` asserted with `ex_ready_o`=0 has no effect. The upstream stage must hold.

## Configuration
- `EX_WB_FORWARD_EN` defined: the `fwd_*` ports are driven as described above.
- Not defined: the `fwd_*` ports still exist but are tied to 0, and no forwarding logic is synthesized.

## Structure
- Package (`riscv_defines.sv`): `RISCV_WORD_WIDTH`, `RISCV_REG_ADDR_WIDTH` (=5), typedef `ex_wb_entry_t` packed struct {data, rd_addr, we}.
- Sub-module `ex_wb_skid`: generic 2-entry skid buffer over `ex_wb_entry_t` holding the FSM. The top level adds x0 masking, branch resolution and forwarding.

## Test plan
- Reset then a single accept {data 0x0000_0005, rd 3, we 1}, `wb_ready_i`=1 -> `wb_valid_o` for one cycle with rd 3 and data 5; `ex_ready_o` stays 1.
- Write to x0: {0xDEAD_BEEF, rd 0, we 1} -> `wb_valid_o`=1, `wb_we_o`=0, `fwd_valid_o`=0.
- Backpressure: `wb_ready_i`=0 with three back-to-back accepts A, B, C -> A and B are taken; `ex_ready_o`=0 from the cycle after B; C is held. Raise `wb_ready_i` -> pops A, B, C in order, no loss or duplicate.
- Branch: `is_branch_i`=1, `alu_result_i`=0xFFFF_FFFF (NE, not equal), target 0x0000_0100 -> `branch_taken_o`=1 for exactly one cycle with target 0x100. Same with `alu_result_i`=0xFFFF_FFFE -> no pulse.
- Branch under backpressure: stage in FULL with `wb_ready_i`=0, accept a taken branch -> pulse still occurs in N+1.
- Reset in SKID state -> next cycle `wb_valid_o`=0 and `ex_ready_o`=1; no stale entry appears after reset is released.
